// File: rtl/ncl_quad_add_bridge_pkg.sv
// Shared types and 1-of-4 / dual-rail encode/decode helpers for the NCL quad adder bridge.
package ncl_quad_add_bridge_pkg;

    typedef enum logic [1:0] {INITW, IDLE, DATA, RETURN} state_t;

    localparam int RAILS = 4;

    function automatic logic [RAILS-1:0] bin2quad(input logic [1:0] v);
        return 4'b0001 << v;
    endfunction

    // Lowest-index rail wins so a corrupted digit still decodes deterministically.
    function automatic logic [1:0] quad2bin(input logic [RAILS-1:0] q);
        return q[0] ? 2'd0 : q[1] ? 2'd1 : q[2] ? 2'd2 : q[3] ? 2'd3 : 2'd0;
    endfunction

    function automatic logic onehot_legal(input logic [RAILS-1:0] q);
        return (q & (q - 4'd1)) == 4'd0;
    endfunction

    function automatic logic [1:0] dual_enc(input logic b);
        return b ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ncl_quad_add_bridge_sync2.sv
// Two-flop synchronizer for the asynchronous NCL chain outputs.
module ncl_sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/ncl_quad_add_bridge.sv
// Clocked source/sink for a ripple chain of quaternary NCL full adders: encodes binary operands
// into 1-of-4 DATA wavefronts, runs the NULL/DATA handshake and returns a binary sum.
module ncl_quad_add_bridge
    import ncl_quad_add_bridge_pkg::*;
#(
    parameter int DIGITS      = 4,
    parameter int TIMEOUT_CYC = 1024,
    parameter int INIT_HOLD   = 4
) (
    input  logic                clk,
    input  logic                init,
    output logic                ncl_init,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [2*DIGITS-1:0] a_bin,
    input  logic [2*DIGITS-1:0] b_bin,
    input  logic                cin,
    output logic [4*DIGITS-1:0] AQ,
    output logic [4*DIGITS-1:0] BQ,
    output logic [1:0]          carryin,
    input  logic                ABCOMP,
    input  logic [4*DIGITS-1:0] sumQ,
    input  logic [1:0]          carryout,
    output logic                sumCOMP,
    output logic                carryCOMP,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [2*DIGITS-1:0] sum_bin,
    output logic                cout,
    output logic                err_timeout,
    output logic                err_illegal
);

    localparam int SW = 3 + 4*DIGITS;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam int HW = $clog2(INIT_HOLD + 1);

    state_t                    state;
    logic [SW-1:0]             sync_q, sync_prev;
    logic                      abcomp_s;
    logic [1:0]                carryout_s;
    logic [DIGITS-1:0][3:0]    sumq_s;
    logic [DIGITS-1:0][3:0]    aq_enc, bq_enc;
    logic [DIGITS-1:0]         dig_any, dig_legal;
    logic [2*DIGITS-1:0]       sum_dec;
    logic [TW-1:0]             tmo_cnt;
    logic [HW-1:0]             hold_cnt;
    logic stable, result_complete, result_null, data_ok, null_ok;
    logic illegal, consume, capture, tmo_run;

    ncl_sync2 #(.W(SW)) u_sync (
        .clk (clk),
        .rst (init),
        .d   ({ABCOMP, carryout, sumQ}),
        .q   (sync_q)
    );

    assign {abcomp_s, carryout_s, sumq_s} = sync_q;

    for (genvar d = 0; d < DIGITS; d++) begin : g_dig
        assign dig_any[d]         = |sumq_s[d];
        assign dig_legal[d]       = onehot_legal(sumq_s[d]);
        assign sum_dec[2*d +: 2]  = quad2bin(sumq_s[d]);
        assign aq_enc[d]          = bin2quad(a_bin[2*d +: 2]);
        assign bq_enc[d]          = bin2quad(b_bin[2*d +: 2]);
    end

    // A decision is only trusted once the synchronized view has held for two cycles,
    // filtering wavefronts that were caught mid-transition.
    assign stable          = (sync_q == sync_prev);
    assign result_complete = (&dig_any) && (carryout_s != 2'b00);
    assign result_null     = (sumq_s == '0) && (carryout_s == 2'b00);
    assign data_ok         = stable && result_complete && abcomp_s;
    assign null_ok         = stable && result_null && !abcomp_s;
    assign illegal         = !(&dig_legal) || (carryout_s == 2'b11);
    assign consume         = out_valid && out_ready;
    assign capture         = (state == DATA) && data_ok && (!out_valid || out_ready);
    assign tmo_run         = ((state == DATA) && !capture && !out_valid) ||
                             ((state == RETURN) && !null_ok);

    always_ff @(posedge clk) begin
        if (init) begin
            state       <= INITW;
            AQ          <= '0;
            BQ          <= '0;
            carryin     <= 2'b00;
            sumCOMP     <= 1'b0;
            carryCOMP   <= 1'b0;
            out_valid   <= 1'b0;
            in_ready    <= 1'b0;
            err_timeout <= 1'b0;
            err_illegal <= 1'b0;
            ncl_init    <= 1'b1;
            hold_cnt    <= HW'(INIT_HOLD);
            tmo_cnt     <= '0;
            sum_bin     <= '0;
            cout        <= 1'b0;
            sync_prev   <= '0;
        end else begin
            sync_prev <= sync_q;
            if (consume) out_valid <= 1'b0;

            // Saturating watchdog; flags a stuck chain but never aborts the handshake.
            if (tmo_run) begin
                if (tmo_cnt != TW'(TIMEOUT_CYC)) tmo_cnt <= tmo_cnt + 1'b1;
                if (tmo_cnt == TW'(TIMEOUT_CYC - 1)) err_timeout <= 1'b1;
            end

            case (state)
                INITW: begin
                    if (hold_cnt != '0) hold_cnt <= hold_cnt - 1'b1;
                    ncl_init <= (hold_cnt != '0);
                    if (hold_cnt == '0 && null_ok) begin
                        in_ready <= 1'b1;
                        state    <= IDLE;
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        AQ       <= aq_enc;
                        BQ       <= bq_enc;
                        carryin  <= dual_enc(cin);
                        in_ready <= 1'b0;
                        tmo_cnt  <= '0;
                        state    <= DATA;
                    end
                end
                DATA: begin
                    if (capture) begin
                        sum_bin     <= sum_dec;
                        cout        <= carryout_s[1] & ~carryout_s[0];
                        out_valid   <= 1'b1;
                        sumCOMP     <= 1'b1;
                        carryCOMP   <= 1'b1;
                        AQ          <= '0;
                        BQ          <= '0;
                        carryin     <= 2'b00;
                        err_illegal <= err_illegal | illegal;
                        tmo_cnt     <= '0;
                        state       <= RETURN;
                    end
                end
                RETURN: begin
                    if (null_ok) begin
                        sumCOMP   <= 1'b0;
                        carryCOMP <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= INITW;
            endcase
        end
    end

endmodule

// File: tb/tb_ncl_quad_add_bridge.sv
// Bench for ncl_quad_add_bridge: behavioural quaternary NCL adder chain with random delays
// plus an arithmetic reference for every returned sum.
module tb_ncl_quad_add_bridge;

    localparam int D  = 2;
    localparam int W  = 2*D;
    localparam int TO = 16;
    localparam int IH = 4;

    logic           clk = 1'b0;
    logic           init = 1'b1;
    logic           ncl_init;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a_bin = '0;
    logic [W-1:0]   b_bin = '0;
    logic           cin = 1'b0;
    logic [4*D-1:0] AQ, BQ, sumQ;
    logic [1:0]     carryin, carryout;
    logic           ABCOMP, sumCOMP, carryCOMP;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [W-1:0]   sum_bin;
    logic           cout, err_timeout, err_illegal;

    logic [4*D-1:0] ch_sum = '0;
    logic [1:0]     ch_cout = 2'b00;
    logic           ch_ab = 1'b0;
    logic           il_force = 1'b0;
    logic           ab_stuck = 1'b0;
    int n_chk = 0;
    int n_fail = 0;

    assign ABCOMP   = ch_ab & ~ab_stuck;
    assign sumQ     = il_force ? {ch_sum[4*D-1:4], 4'b0011} : ch_sum;
    assign carryout = ch_cout;

    ncl_quad_add_bridge #(.DIGITS(D), .TIMEOUT_CYC(TO), .INIT_HOLD(IH)) dut (
        .clk(clk), .init(init), .ncl_init(ncl_init), .in_valid(in_valid), .in_ready(in_ready),
        .a_bin(a_bin), .b_bin(b_bin), .cin(cin), .AQ(AQ), .BQ(BQ), .carryin(carryin),
        .ABCOMP(ABCOMP), .sumQ(sumQ), .carryout(carryout), .sumCOMP(sumCOMP),
        .carryCOMP(carryCOMP), .out_valid(out_valid), .out_ready(out_ready),
        .sum_bin(sum_bin), .cout(cout), .err_timeout(err_timeout), .err_illegal(err_illegal)
    );

    always #5 clk = ~clk;

    function automatic int rail_val(input logic [3:0] q);
        for (int r = 0; r < 4; r++) if (q[r]) return r;
        return 0;
    endfunction

    function automatic bit all_data(input logic [4*D-1:0] q);
        for (int d = 0; d < D; d++) if (q[4*d +: 4] == 4'b0000) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [W:0] ref_add(input logic [W-1:0] a, input logic [W-1:0] b, input logic c);
        return {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
    endfunction

    // Ripple chain: digits settle one by one with random gate delays, completion rises last.
    initial begin : chain
        int c, s;
        forever begin
            @(posedge clk);
            #1;
            if (ncl_init === 1'b1) begin
                ch_sum = '0; ch_cout = 2'b00; ch_ab = 1'b0;
            end else if (!ch_ab && sumCOMP === 1'b0 && all_data(AQ) && all_data(BQ) && carryin != 2'b00) begin
                c = carryin[1] ? 1 : 0;
                for (int d = 0; d < D; d++) begin
                    s = rail_val(AQ[4*d +: 4]) + rail_val(BQ[4*d +: 4]) + c;
                    #($urandom_range(1, 2));
                    ch_sum[4*d + s%4] = 1'b1;
                    c = s / 4;
                end
                #($urandom_range(1, 2)); ch_cout[c] = 1'b1;
                #($urandom_range(1, 2)); ch_ab = 1'b1;
            end else if (ch_ab && sumCOMP === 1'b1 && AQ == '0 && BQ == '0 && carryin == 2'b00) begin
                for (int d = 0; d < D; d++) begin
                    #($urandom_range(1, 2));
                    ch_sum[4*d +: 4] = 4'b0000;
                end
                #($urandom_range(1, 2)); ch_cout = 2'b00;
                #($urandom_range(1, 2)); ch_ab = 1'b0;
            end
        end
    end

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, output bit tmo);
        int n;
        @(negedge clk);
        a_bin = a; b_bin = b; cin = c; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        tmo = !in_ready;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic recv(output logic [W-1:0] s, output logic co, output logic [4:0] snap, output bit tmo);
        int n;
        n = 0;
        while (!(out_valid && out_ready) && n < 100) begin @(negedge clk); n++; end
        tmo  = !(out_valid && out_ready);
        s    = sum_bin;
        co   = cout;
        snap = {sumCOMP, carryCOMP, AQ == '0, BQ == '0, carryin == 2'b00};
        @(negedge clk);
    endtask

    task automatic wait_idle(output bit tmo);
        int n;
        n = 0;
        while (!in_ready && n < 100) begin @(negedge clk); n++; end
        tmo = !in_ready;
    endtask

    task automatic count_hold(output int n);
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ncl_init) n++;
            else break;
        end
    endtask

    task automatic test_reset();
        int n;
        bit tmo;
        init = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({AQ, BQ, carryin, sumCOMP, carryCOMP, out_valid, in_ready, ncl_init, err_timeout, err_illegal}
                !== {18'h0, 7'b0000100}) begin
            n_fail++;
            $display("FAIL reset_state: got %h expected %h",
                {AQ, BQ, carryin, sumCOMP, carryCOMP, out_valid, in_ready, ncl_init, err_timeout, err_illegal},
                {18'h0, 7'b0000100});
        end
        init = 1'b0;
        count_hold(n);
        n_chk++;
        if (n !== IH) begin n_fail++; $display("FAIL reset_init_hold: got %0d expected %0d", n, IH); end
        wait_idle(tmo);
        n_chk++;
        if (tmo) begin n_fail++; $display("FAIL reset_to_idle: in_ready got 0 expected 1"); end
    endtask

    task automatic test_basic();
        logic [W-1:0] s;
        logic co;
        logic [4:0] snap;
        bit tmo;
        int n;
        send(4'd3, 4'd2, 1'b1, tmo);
        n_chk++;
        if (tmo || {AQ, BQ, carryin} !== {8'b0001_1000, 8'b0001_0100, 2'b10}) begin
            n_fail++;
            $display("FAIL basic_encode: got %h expected %h", {AQ, BQ, carryin}, {8'b0001_1000, 8'b0001_0100, 2'b10});
        end
        recv(s, co, snap, tmo);
        n_chk++;
        if (tmo || snap !== 5'b11111) begin
            n_fail++; $display("FAIL basic_capture_state: got %b expected 11111 (tmo=%0d)", snap, tmo);
        end
        n_chk++;
        if ({co, s} !== ref_add(4'd3, 4'd2, 1'b1)) begin
            n_fail++; $display("FAIL basic_sum: got %h expected %h", {co, s}, ref_add(4'd3, 4'd2, 1'b1));
        end
        n = 0;
        while (sumCOMP && n < 100) begin @(negedge clk); n++; end
        n_chk++;
        if ({sumCOMP, carryCOMP, in_ready} !== 3'b001) begin
            n_fail++; $display("FAIL basic_return: got %b expected 001", {sumCOMP, carryCOMP, in_ready});
        end
    endtask

    task automatic test_carry();
        logic [W-1:0] s;
        logic co;
        logic [4:0] snap;
        bit tmo, tmo2;
        send(4'd15, 4'd1, 1'b0, tmo);
        recv(s, co, snap, tmo2);
        n_chk++;
        if (tmo || tmo2 || {co, s} !== ref_add(4'd15, 4'd1, 1'b0)) begin
            n_fail++; $display("FAIL carry_wrap: got %h expected %h", {co, s}, ref_add(4'd15, 4'd1, 1'b0));
        end
    endtask

    task automatic test_random();
        logic [W-1:0] a, b, s;
        logic c, co;
        logic [4:0] snap;
        bit tmo, tmo2;
        for (int i = 0; i < 100; i++) begin
            a = W'($urandom()); b = W'($urandom()); c = 1'($urandom());
            send(a, b, c, tmo);
            recv(s, co, snap, tmo2);
            n_chk++;
            if (tmo || tmo2 || {co, s} !== ref_add(a, b, c)) begin
                n_fail++;
                $display("FAIL random_sum[%0d] a=%h b=%h c=%0d: got %h expected %h", i, a, b, c, {co, s}, ref_add(a, b, c));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a1, b1, a2, b2, s;
        logic c1, c2, co;
        logic [4:0] snap;
        bit t1, t2, t3, t4;
        a1 = W'($urandom()); b1 = W'($urandom()); c1 = 1'($urandom());
        a2 = W'($urandom()); b2 = W'($urandom()); c2 = 1'($urandom());
        out_ready = 1'b0;
        send(a1, b1, c1, t1);
        send(a2, b2, c2, t2);
        repeat (20) @(negedge clk);
        n_chk++;
        if (t1 || t2 || {sumCOMP, in_ready, out_valid} !== 3'b001) begin
            n_fail++; $display("FAIL stall_state: got %b expected 001", {sumCOMP, in_ready, out_valid});
        end
        n_chk++;
        if ({cout, sum_bin} !== ref_add(a1, b1, c1)) begin
            n_fail++; $display("FAIL stall_hold: got %h expected %h", {cout, sum_bin}, ref_add(a1, b1, c1));
        end
        out_ready = 1'b1;
        recv(s, co, snap, t3);
        n_chk++;
        if (t3 || {co, s} !== ref_add(a1, b1, c1)) begin
            n_fail++; $display("FAIL b2b_first: got %h expected %h", {co, s}, ref_add(a1, b1, c1));
        end
        recv(s, co, snap, t4);
        n_chk++;
        if (t4 || {co, s} !== ref_add(a2, b2, c2)) begin
            n_fail++; $display("FAIL b2b_second: got %h expected %h", {co, s}, ref_add(a2, b2, c2));
        end
    endtask

    task automatic test_illegal();
        logic [W-1:0] a, b, s;
        logic c, co;
        logic [W:0] r;
        logic [4:0] snap;
        bit t0, t1, t2;
        wait_idle(t0);
        n_chk++;
        if (t0 || err_illegal !== 1'b0) begin n_fail++; $display("FAIL illegal_pre: got %b expected 0", err_illegal); end
        a = W'($urandom()); b = W'($urandom()); c = 1'($urandom());
        r = ref_add(a, b, c);
        il_force = 1'b1;
        send(a, b, c, t1);
        recv(s, co, snap, t2);
        il_force = 1'b0;
        n_chk++;
        if (t1 || t2 || err_illegal !== 1'b1 || {co, s} !== {r[W:2], 2'b00}) begin
            n_fail++;
            $display("FAIL illegal_capture: got err=%b sum=%h expected err=1 sum=%h", err_illegal, {co, s}, {r[W:2], 2'b00});
        end
        a = W'($urandom()); b = W'($urandom()); c = 1'($urandom());
        send(a, b, c, t1);
        recv(s, co, snap, t2);
        n_chk++;
        if (t1 || t2 || err_illegal !== 1'b1 || {co, s} !== ref_add(a, b, c)) begin
            n_fail++;
            $display("FAIL illegal_recover: got err=%b sum=%h expected err=1 sum=%h", err_illegal, {co, s}, ref_add(a, b, c));
        end
    endtask

    task automatic test_timeout();
        logic [W-1:0] s;
        logic co;
        logic [4:0] snap;
        bit t0, t1, t2;
        wait_idle(t0);
        n_chk++;
        if (t0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_pre: got %b expected 0", err_timeout); end
        ab_stuck = 1'b1;
        send(4'd9, 4'd6, 1'b1, t1);
        repeat (10) @(negedge clk);
        n_chk++;
        if (t1 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got %b expected 0", err_timeout); end
        repeat (10) @(negedge clk);
        n_chk++;
        if ({err_timeout, out_valid, in_ready} !== 3'b100) begin
            n_fail++; $display("FAIL timeout_set: got %b expected 100", {err_timeout, out_valid, in_ready});
        end
        ab_stuck = 1'b0;
        recv(s, co, snap, t2);
        n_chk++;
        if (t2 || {co, s} !== ref_add(4'd9, 4'd6, 1'b1)) begin
            n_fail++; $display("FAIL timeout_complete: got %h expected %h", {co, s}, ref_add(4'd9, 4'd6, 1'b1));
        end
    endtask

    task automatic test_init_abort();
        logic [W-1:0] s;
        logic co;
        logic [4:0] snap;
        bit t0, t1, t2;
        int n;
        wait_idle(t0);
        send(4'd7, 4'd12, 1'b0, t1);
        init = 1'b1;
        @(negedge clk);
        n_chk++;
        if (t0 || t1 || {AQ, BQ, carryin, sumCOMP, carryCOMP, out_valid, in_ready, ncl_init, err_timeout, err_illegal}
                !== {18'h0, 7'b0000100}) begin
            n_fail++;
            $display("FAIL abort_state: got %h expected %h",
                {AQ, BQ, carryin, sumCOMP, carryCOMP, out_valid, in_ready, ncl_init, err_timeout, err_illegal},
                {18'h0, 7'b0000100});
        end
        init = 1'b0;
        count_hold(n);
        n_chk++;
        if (n !== IH) begin n_fail++; $display("FAIL abort_init_hold: got %0d expected %0d", n, IH); end
        wait_idle(t0);
        n_chk++;
        if (t0) begin n_fail++; $display("FAIL abort_to_idle: in_ready got 0 expected 1"); end
        send(4'd10, 4'd11, 1'b1, t1);
        recv(s, co, snap, t2);
        n_chk++;
        if (t1 || t2 || {co, s} !== ref_add(4'd10, 4'd11, 1'b1)) begin
            n_fail++; $display("FAIL abort_next_txn: got %h expected %h", {co, s}, ref_add(4'd10, 4'd11, 1'b1));
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_random();
        test_back_to_back();
        test_illegal();
        test_timeout();
        test_init_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
